// File: rtl/floating_point_multiply.sv
`default_nettype none
// ============================================================================
// Module   : floating_point_multiply
// Brief    : Pipelined IEEE-754 binary32 multiplier with start/last framing.
// Revision : 1.0 - initial release
// ============================================================================
module floating_point_multiply #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validIn,
  input  logic        startIn,
  input  logic        lastIn,
  input  logic [31:0] aIn,
  input  logic [31:0] bIn,
  output logic        validOut,
  output logic        startOut,
  output logic        lastOut,
  output logic [31:0] dataOut
);

  // Operands are registered on entry so classification starts from a flop.
  logic        r_in_valid, r_in_start, r_in_last;
  logic [31:0] r_in_a, r_in_b;

  logic        r_s1_valid, r_s1_start, r_s1_last;
  logic        r_s1_sign, r_s1_nan, r_s1_inf, r_s1_zero;
  logic [23:0] r_s1_ma, r_s1_mb;
  logic [9:0]  r_s1_exp;

  logic        r_s2_valid, r_s2_start, r_s2_last;
  logic        r_s2_sign, r_s2_nan, r_s2_inf, r_s2_zero;
  logic [47:0] r_s2_prod;
  logic [9:0]  r_s2_exp;

  logic [7:0]  w_exp_a, w_exp_b;
  logic        w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;

  assign w_exp_a  = r_in_a[30:23];
  assign w_exp_b  = r_in_b[30:23];
  assign w_zero_a = (w_exp_a == 8'h00);
  assign w_zero_b = (w_exp_b == 8'h00);
  assign w_inf_a  = (w_exp_a == 8'hFF) && (r_in_a[22:0] == 23'h0);
  assign w_inf_b  = (w_exp_b == 8'hFF) && (r_in_b[22:0] == 23'h0);
  assign w_nan_a  = (w_exp_a == 8'hFF) && (r_in_a[22:0] != 23'h0);
  assign w_nan_b  = (w_exp_b == 8'hFF) && (r_in_b[22:0] != 23'h0);

  logic              w_hi, w_guard, w_sticky, w_inc;
  logic [22:0]       w_mant;
  logic [23:0]       w_round;
  logic signed [9:0] w_exp_fin;
  logic [31:0]       w_result;

  assign w_hi      = r_s2_prod[47];
  assign w_mant    = w_hi ? r_s2_prod[46:24] : r_s2_prod[45:23];
  assign w_guard   = w_hi ? r_s2_prod[23]    : r_s2_prod[22];
  assign w_sticky  = w_hi ? (|r_s2_prod[22:0]) : (|r_s2_prod[21:0]);
  assign w_inc     = w_guard & (w_sticky | w_mant[0]);
  assign w_round   = {1'b0, w_mant} + {23'h0, w_inc};
  // A rounding carry leaves w_round[22:0] at zero, so only the exponent moves.
  assign w_exp_fin = r_s2_exp + {9'h0, w_hi} + {9'h0, w_round[23]};

  always_comb begin
    w_result = {r_s2_sign, w_exp_fin[7:0], w_round[22:0]};
    if (r_s2_nan)
      w_result = NAN_VALUE;
    else if (r_s2_inf)
      w_result = {r_s2_sign, 8'hFF, 23'h0};
    else if (r_s2_zero)
      w_result = {r_s2_sign, 31'h0};
    else if (w_exp_fin >= 10'sd255)
      w_result = {r_s2_sign, 8'hFF, 23'h0};
    else if (w_exp_fin <= 10'sd0)
      w_result = {r_s2_sign, 31'h0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_in_start <= 1'b0;
      r_in_last  <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_start <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_start <= 1'b0;
      r_s2_last  <= 1'b0;
      validOut   <= 1'b0;
      startOut   <= 1'b0;
      lastOut    <= 1'b0;
      dataOut    <= 32'h0;
    end else begin
      r_in_valid <= validIn;
      r_in_start <= validIn & startIn;
      r_in_last  <= validIn & lastIn;
      r_s1_valid <= r_in_valid;
      r_s1_start <= r_in_start;
      r_s1_last  <= r_in_last;
      r_s2_valid <= r_s1_valid;
      r_s2_start <= r_s1_start;
      r_s2_last  <= r_s1_last;
      validOut   <= r_s2_valid;
      startOut   <= r_s2_start;
      lastOut    <= r_s2_last;
      if (r_s2_valid)
        dataOut <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    r_in_a    <= aIn;
    r_in_b    <= bIn;
    r_s1_sign <= r_in_a[31] ^ r_in_b[31];
    r_s1_nan  <= w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
    r_s1_inf  <= w_inf_a | w_inf_b;
    r_s1_zero <= w_zero_a | w_zero_b;
    r_s1_ma   <= {1'b1, r_in_a[22:0]};
    r_s1_mb   <= {1'b1, r_in_b[22:0]};
    r_s1_exp  <= {2'b00, w_exp_a} + {2'b00, w_exp_b} - 10'd127;
    r_s2_sign <= r_s1_sign;
    r_s2_nan  <= r_s1_nan;
    r_s2_inf  <= r_s1_inf;
    r_s2_zero <= r_s1_zero;
    r_s2_prod <= {24'h0, r_s1_ma} * {24'h0, r_s1_mb};
    r_s2_exp  <= r_s1_exp;
  end

endmodule
`default_nettype wire
